if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch front end; sits directly upstream of the compressed-instruction expansion stage.
- Generates word-aligned fetch addresses and drives the instruction-memory request/grant/response interface.
- Buffers returned 32-bit words in a small in-order queue, presents the head word and its PC to the expansion stage, and flushes on redirect (branch/jump/trap).

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2, queue entries; power of two, at least 2; also the maximum outstanding-plus-buffered word count.

Ports:
- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- stall  in  1  downstream stall; while high, consume is ignored and the head entry is held.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; may be halfword-aligned.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted in this cycle.
- imem_rvalid  in  1  read data valid; responses are in order, one per grant, at least 1 cycle after the grant.
- imem_rdata  in  32  read data.
- instruction  out  32  head-of-queue word, fed to the expansion stage.
- instr_pc  out  32  PC of the head word.
- half_start  out  1  head word is the first after a halfword redirect; the low halfword must be skipped.
- instr_valid  out  1  the queue is non-empty.
- consume  in  1  pop the head entry (honoured only when instr_valid=1 and stall=0).

Behaviour:
- Reset values, with aresetn low at any time, including mid-transaction:
  - imem_req=0; imem_addr=RESET_PC; instruction=32'h0000_0013 (NOP); instr_pc=RESET_PC; half_start=0; instr_valid=0.
  - Queue empty; outstanding=0; discard=0.
- Credits:
  - outstanding counter (width clog2(DEPTH)+1): +1 on imem_req&imem_gnt, -1 on imem_rvalid. Simultaneous +1/-1 leaves it unchanged.
  - imem_req is asserted while (outstanding + occupancy) < DEPTH and redirect=0.
  - imem_addr and imem_req hold stable until imem_gnt, except on redirect. On redirect the pending request is withdrawn; the memory tolerates withdrawn requests.
  - On each grant, fetch_pc += 4, wrapping modulo 2^32 (32'hFFFF_FFFC to 0).
- Response path:
  - An imem_rvalid with discard=0 writes {imem_rdata, word PC, half flag} at the tail.
  - Entry PCs are tracked in a PC FIFO or per-entry register.
  - Registered: a response in cycle N gives instr_valid=1 in cycle N+1 if the queue was empty.
  - Minimum redirect-to-instr_valid latency is 3 cycles with 1-cycle memory.
- Pop: consume & instr_valid & ~stall advances the head.
  - Push and pop in the same cycle are both allowed when full; occupancy is unchanged.
  - Push never occurs when full, because the credit rule guarantees it.
- Empty: instr_valid=0; instruction=NOP; instr_pc holds its last value.
- Redirect, highest priority; overrides push, pop and grant in the same cycle:
  - Queue cleared, so instr_valid=0 the next cycle.
  - fetch_pc <= {redirect_pc[31:2],2'b00}; pending_half <= redirect_pc[1].
  - discard <= outstanding - imem_rvalid (the response in the redirect cycle is dropped).
  - Later imem_rvalid with discard>0: decrement discard and drop the data.
  - New requests may issue during discard; in-order return guarantees stale data arrives first.
  - The first word enqueued after the redirect carries half_start=pending_half, and pending_half then clears.
  - instr_pc for that entry = {word addr[31:2], redirect_pc[1], 1'b0}; later entries use word addresses.
- Back-to-back redirects: each one recomputes discard from the current outstanding count; the last one wins.
- No combinational path from imem_rdata to instruction.
- Combinational paths from redirect to imem_req are allowed.

Test Plan:
- Reset release with a 1-cycle memory that always grants:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - instr_valid rises 2 cycles after the first grant.
  - instruction equals mem[0x0], then mem[0x4] with instr_pc 0x4, with consume held at 1.
- consume=0 with DEPTH=2:
  - After 2 words are enqueued, imem_req=0 and no further grant occurs.
  - Asserting consume for 1 cycle allows exactly one new request.
- stall=1 with consume=1 for 5 cycles: instruction and instr_pc remain constant and there are no pops.
- Redirect to 0x0000_0102 while 2 responses are outstanding:
  - Both stale responses are dropped.
  - The next fetch address is 0x100.
  - The first instr_valid entry has instr_pc=0x102 and half_start=1; the following entry has 0x104 and half_start=0.
- Redirect in the same cycle as imem_rvalid and consume: the rvalid data is dropped, discard = outstanding-1, and the queue is empty next cycle.
- Assert aresetn low while the queue holds 2 entries and 1 response is outstanding:
  - All outputs return to their reset values immediately.
  - A late imem_rvalid after reset is not enqueued (bench holds memory quiet during reset).
- PC wrap: redirect to 0xFFFF_FFFC gives fetch addresses 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// Instruction-memory request/grant/response bundle between the fetch queue
// (master) and the instruction memory (slave).
interface if_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues word-aligned fetches under a credit
// scheme, buffers returned words in an in-order queue, presents the head
// word with its PC, and flushes/restarts on redirect while dropping stale
// in-flight responses.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  if_fetch_queue_if.master       imem,
  output logic [31:0]            instruction,
  output logic [31:0]            instr_pc,
  output logic                   half_start,
  output logic                   instr_valid,
  input  logic                   consume
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  // Control state
  logic             req_en;
  logic [31:2]      fetch_pc;
  logic [31:2]      resp_pc;
  logic             pending_half;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    discard;
  logic [CW-1:0]    count;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [31:0]      pc_hold;

  // Queue storage (no reset: validity is tracked by count)
  logic [31:0]      data_mem [DEPTH];
  logic [31:1]      pc_mem   [DEPTH];

  logic [CW:0]      inflight;
  logic             fire;
  logic             push;
  logic             pop;
  logic             unused_pc_lsb;

  // Redirect targets are halfword-aligned at most; bit 0 carries no information.
  assign unused_pc_lsb = redirect_pc[0];

  // Words in flight plus words buffered may never exceed the queue depth, so a
  // response always finds a free slot. req_en keeps the request low while in
  // reset and for the first cycle after release.
  assign inflight       = {1'b0, outstanding} + {1'b0, count};
  assign imem.imem_req  = req_en & (inflight < DEPTH_W) & ~redirect;
  assign imem.imem_addr = {fetch_pc, 2'b00};

  assign fire = imem.imem_req & imem.imem_gnt;
  assign push = imem.imem_rvalid & (discard == '0) & ~redirect;
  assign pop  = consume & instr_valid & ~stall & ~redirect;

  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? data_mem[rd_ptr] : NOP;
  assign instr_pc    = instr_valid ? {pc_mem[rd_ptr], 1'b0} : pc_hold;
  assign half_start  = instr_valid & pc_mem[rd_ptr][1];

  // Fetch address, credit, discard and queue-pointer bookkeeping; redirect
  // overrides every other update in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req_en       <= 1'b0;
      fetch_pc     <= RESET_PC[31:2];
      resp_pc      <= RESET_PC[31:2];
      pending_half <= 1'b0;
      outstanding  <= '0;
      discard      <= '0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      pc_hold      <= RESET_PC;
    end else begin
      req_en  <= 1'b1;
      pc_hold <= instr_pc;
      if (redirect) begin
        fetch_pc     <= redirect_pc[31:2];
        resp_pc      <= redirect_pc[31:2];
        pending_half <= redirect_pc[1];
        // Everything still in flight is stale, including the response (if
        // any) arriving right now, which is dropped here.
        outstanding  <= outstanding - CW'(imem.imem_rvalid);
        discard      <= outstanding - CW'(imem.imem_rvalid);
        count        <= '0;
        rd_ptr       <= '0;
        wr_ptr       <= '0;
      end else begin
        if (fire) begin
          fetch_pc <= fetch_pc + 30'd1;
        end
        case ({fire, imem.imem_rvalid})
          2'b10:   outstanding <= outstanding + CW'(1);
          2'b01:   outstanding <= outstanding - CW'(1);
          default: outstanding <= outstanding;
        endcase
        if (imem.imem_rvalid && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (push) begin
          wr_ptr       <= wr_ptr + AW'(1);
          resp_pc      <= resp_pc + 30'd1;
          pending_half <= 1'b0;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Capture an accepted response at the tail; the first word after a
  // halfword redirect carries the odd-halfword PC.
  always_ff @(posedge aclk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem.imem_rdata;
      pc_mem[wr_ptr]   <= {resp_pc, pending_half};
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized scoreboard bench for if_fetch_queue: a memory model grants and
// returns words in order, the stimulus side pushes the expected instruction
// stream (derived from the current fetch target), and a monitor pops and
// compares every consumed head entry.
module tb_if_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        half;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  logic        aclk;
  logic        aresetn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        half_start;
  logic        instr_valid;
  logic        consume;

  if_fetch_queue_if bus ();

  if_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .half_start  (half_start),
    .instr_valid (instr_valid),
    .consume     (consume)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          pops    = 0;
  exp_t        exp_q[$];
  req_t        pend[$];
  logic [31:0] grant_log[$];
  int          grant_cyc[$];
  int          gnt_pct   = 100;
  int          lat_min   = 1;
  int          lat_extra = 0;
  logic [31:0] str_addr;
  logic        str_half;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Expected stream: consecutive words from the fetch target; only the first
  // entry after a halfword target carries the odd-halfword PC.
  function automatic void sb_restart(input logic [31:0] pc);
    exp_q.delete();
    str_addr = {pc[31:2], 2'b00};
    str_half = pc[1];
  endfunction

  function automatic void sb_fill();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.data = memf(str_addr);
      e.pc   = str_addr | (str_half ? 32'h2 : 32'h0);
      e.half = str_half;
      exp_q.push_back(e);
      str_addr = str_addr + 32'd4;
      str_half = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
    sb_fill();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    sb_restart(pc);
    sb_fill();
    tick();
    redirect = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, bus.imem_req}, 32'd0);
    chk({tag, "_addr"},  bus.imem_addr, RESET_PC);
    chk({tag, "_instr"}, instruction, NOP);
    chk({tag, "_pc"},    instr_pc, RESET_PC);
    chk({tag, "_half"},  {31'd0, half_start}, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  // Memory model: random grants, in-order responses at least one cycle later.
  initial begin
    logic        req_pend;
    logic [31:0] addr_prev;
    req_t        r;
    req_pend = 1'b0;
    addr_prev = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        pend.delete();
        req_pend = 1'b0;
      end else begin
        if (req_pend && !redirect) begin
          chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
          chk("addr_hold", bus.imem_addr, addr_prev);
        end
        if (bus.imem_req && bus.imem_gnt) begin
          r.addr = bus.imem_addr;
          r.due  = cyc + lat_min + int'($urandom_range(lat_extra));
          pend.push_back(r);
          grant_log.push_back(bus.imem_addr);
          grant_cyc.push_back(cyc);
        end
        req_pend  = bus.imem_req & ~bus.imem_gnt;
        addr_prev = bus.imem_addr;
      end
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
      end else begin
        bus.imem_gnt = (int'($urandom_range(99)) < gnt_pct);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = memf(pend[0].addr);
          void'(pend.pop_front());
        end else begin
          bus.imem_rvalid = 1'b0;
          bus.imem_rdata  = $urandom;
        end
      end
    end
  end

  // Monitor: compares every consumed head entry against the scoreboard.
  initial begin
    logic redir_prev;
    exp_t e;
    redir_prev = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        redir_prev = 1'b0;
      end else begin
        if (redir_prev) chk("flush_empty", {31'd0, instr_valid}, 32'd0);
        if (!instr_valid) begin
          chk("empty_nop", instruction, NOP);
          chk("empty_half", {31'd0, half_start}, 32'd0);
        end else if (consume && !stall && !redirect) begin
          if (exp_q.size() == 0) begin
            timeout_fail("sb_underflow");
          end else begin
            e = exp_q.pop_front();
            chk("pop_instr", instruction, e.data);
            chk("pop_pc", instr_pc, e.pc);
            chk("pop_half", {31'd0, half_start}, {31'd0, e.half});
            pops++;
          end
        end
        redir_prev = redirect;
      end
    end
  end

  // Stimulus
  initial begin
    int  first_valid;
    int  n;
    bit  found;
    logic [31:0] rpc;
    aresetn = 1'b0;
    stall = 1'b0;
    consume = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    sb_restart(RESET_PC);
    repeat (3) @(posedge aclk);
    #1;
    chk_reset_outputs("rst");

    // Startup with an always-granting 1-cycle memory.
    tick();
    aresetn = 1'b1;
    consume = 1'b1;
    first_valid = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (instr_valid && first_valid < 0) first_valid = cyc;
      tick();
    end
    if (grant_log.size() < 3 || first_valid < 0) begin
      timeout_fail("startup");
    end else begin
      chk("addr0", grant_log[0], 32'h0);
      chk("addr1", grant_log[1], 32'h4);
      chk("addr2", grant_log[2], 32'h8);
      chk("first_valid_lat", 32'(first_valid - grant_cyc[0]), 32'd2);
    end

    // Credit limit: no consumption fills the queue and stops requests.
    gnt_pct = 70;
    lat_extra = 3;
    consume = 1'b0;
    repeat (40) tick();
    @(negedge aclk);
    chk("full_valid", {31'd0, instr_valid}, 32'd1);
    chk("full_noreq", {31'd0, bus.imem_req}, 32'd0);
    n = grant_log.size();
    repeat (10) tick();
    chk("full_nogrant", 32'(grant_log.size()), 32'(n));
    consume = 1'b1;
    tick();
    consume = 1'b0;
    repeat (30) tick();
    chk("one_more_grant", 32'(grant_log.size()), 32'(n + 1));

    // Stall holds the head.
    stall = 1'b1;
    consume = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instruction, exp_q[0].data);
      chk("stall_pc", instr_pc, exp_q[0].pc);
      tick();
    end
    stall = 1'b0;

    // Redirect to a halfword target with two responses outstanding.
    gnt_pct = 100;
    lat_min = 4;
    lat_extra = 0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      #1;
      if (pend.size() == 2) found = 1'b1;
    end
    if (!found) timeout_fail("two_outstanding");
    n = grant_log.size();
    lat_min = 1;
    do_redirect(32'h0000_0102);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (grant_log.size() > n) found = 1'b1;
    end
    if (!found) timeout_fail("redir_grant");
    else chk("redir_addr", grant_log[n], 32'h0000_0100);
    repeat (20) tick();

    // Redirect in the same cycle as a response and a consume.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      #1;
      if (bus.imem_rvalid) found = 1'b1;
    end
    if (!found) timeout_fail("rvalid_redirect");
    do_redirect(32'h0000_0040);
    repeat (15) tick();

    // Address wrap.
    n = grant_log.size();
    do_redirect(32'hFFFF_FFFC);
    repeat (20) tick();
    if (grant_log.size() < n + 2) begin
      timeout_fail("wrap");
    end else begin
      chk("wrap_addr0", grant_log[n], 32'hFFFF_FFFC);
      chk("wrap_addr1", grant_log[n + 1], 32'h0000_0000);
    end

    // Reset while words are buffered and a response is in flight.
    lat_min = 3;
    consume = 1'b0;
    repeat (20) tick();
    consume = 1'b1;
    tick();
    consume = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      #1;
      if (pend.size() == 1) found = 1'b1;
    end
    if (!found) timeout_fail("reset_outstanding");
    aresetn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (3) tick();
    sb_restart(RESET_PC);
    sb_fill();
    aresetn = 1'b1;
    consume = 1'b1;
    @(negedge aclk);
    chk("post_rst_empty", {31'd0, instr_valid}, 32'd0);
    lat_min = 1;
    repeat (20) tick();

    // Randomized traffic.
    gnt_pct = 70;
    lat_extra = 3;
    for (int i = 0; i < 3000; i++) begin
      tick();
      consume = ($urandom_range(9) < 7);
      stall   = ($urandom_range(9) < 2);
      if ($urandom_range(99) < 3) begin
        rpc = $urandom & 32'hFFFF_FFFE;
        if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000E);
        do_redirect(rpc);
      end
    end
    consume = 1'b1;
    stall = 1'b0;
    repeat (20) tick();
    chk("enough_pops", {31'd0, pops >= 300}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
